// File: rtl/bk_wide_add_seq_pkg.sv
// Shared definitions for the wide-add sequencer and related wide arithmetic stages.
package bk_wide_add_seq_pkg;

  // Width of one adder slice chunk.
  localparam int SLICE_W = 16;

  // Sequencer control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Signed two's-complement overflow: both operands share a sign that the result lacks.
  function automatic logic ovf_flag(input logic sign_a, input logic sign_b, input logic sign_s);
    return (sign_a == sign_b) && (sign_s != sign_a);
  endfunction

endpackage

// File: rtl/bk_wide_add_seq.sv
// Multi-cycle wide adder/subtractor sequencer around an external 16-bit adder slice.
// Operands are streamed LSB chunk first, one chunk per cycle, with the carry chained
// through a register; the collected sum is presented with carry-out and overflow flags.
module bk_wide_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*WORDS-1:0]   in_a,
  input  logic [16*WORDS-1:0]   in_b,
  input  logic                  in_cin,
  input  logic                  in_sub,
  output logic [15:0]           add_a,
  output logic [15:0]           add_b,
  output logic                  add_cin,
  input  logic [16:0]           add_res,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*WORDS-1:0]   out_sum,
  output logic                  out_cout,
  output logic                  out_ovf
);
  import bk_wide_add_seq_pkg::*;

  localparam int N     = SLICE_W * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;
  logic [N-1:0]       a_q;
  logic [N-1:0]       b_q;      // B already inverted for subtract
  logic               sign_a_q;
  logic               sign_b_q;
  logic [N-1:0]       sum_q;
  logic               ovf_q;
  logic               last_chunk;

  assign last_chunk = (idx_q == IDX_W'(WORDS - 1));

  // State register.
  // NOTE: every clocked process uses non-blocking (<=) assignments so all registers
  // sample the pre-edge values together; blocking here would create ordering races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and handshake/slice outputs.
  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        add_a   = a_q[SLICE_W*idx_q +: SLICE_W];
        add_b   = b_q[SLICE_W*idx_q +: SLICE_W];
        add_cin = carry_q;
        if (last_chunk) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, chunk stepping, carry chaining and result collection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      sum_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q      <= in_a;
            b_q      <= in_sub ? ~in_b : in_b;
            sign_a_q <= in_a[N-1];
            sign_b_q <= in_sub ? ~in_b[N-1] : in_b[N-1];
            carry_q  <= in_sub ? 1'b1 : in_cin;
            idx_q    <= '0;
          end
        end
        RUN: begin
          sum_q[SLICE_W*idx_q +: SLICE_W] <= add_res[SLICE_W-1:0];
          carry_q <= add_res[SLICE_W];
          if (last_chunk) ovf_q <= ovf_flag(sign_a_q, sign_b_q, add_res[SLICE_W-1]);
          else            idx_q <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_sum  = sum_q;
  assign out_cout = carry_q;
  assign out_ovf  = ovf_q;

endmodule

// File: tb/tb_bk_wide_add_seq.sv
// Testbench for bk_wide_add_seq: WORDS=4 and WORDS=1 instances, each with a
// behavioural adder slice on add_*, checked against a queue of expected results.
module tb_bk_wide_add_seq;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  exp_t q4[$];
  exp_t q1[$];

  // WORDS=4 instance
  logic        in_valid4 = 1'b0, in_cin4 = 1'b0, in_sub4 = 1'b0, out_ready4 = 1'b0;
  logic [63:0] in_a4 = '0, in_b4 = '0;
  logic        in_ready4, add_cin4, out_valid4, out_cout4, out_ovf4;
  logic [15:0] add_a4, add_b4;
  logic [16:0] add_res4;
  logic [63:0] out_sum4;

  assign add_res4 = {1'b0, add_a4} + {1'b0, add_b4} + {16'd0, add_cin4};

  bk_wide_add_seq #(.WORDS(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_a(in_a4), .in_b(in_b4),
    .in_cin(in_cin4), .in_sub(in_sub4),
    .add_a(add_a4), .add_b(add_b4), .add_cin(add_cin4), .add_res(add_res4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_sum(out_sum4),
    .out_cout(out_cout4), .out_ovf(out_ovf4)
  );

  // WORDS=1 instance
  logic        in_valid1 = 1'b0, in_cin1 = 1'b0, in_sub1 = 1'b0, out_ready1 = 1'b0;
  logic [15:0] in_a1 = '0, in_b1 = '0;
  logic        in_ready1, add_cin1, out_valid1, out_cout1, out_ovf1;
  logic [15:0] add_a1, add_b1;
  logic [16:0] add_res1;
  logic [15:0] out_sum1;

  assign add_res1 = {1'b0, add_a1} + {1'b0, add_b1} + {16'd0, add_cin1};

  bk_wide_add_seq #(.WORDS(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_a(in_a1), .in_b(in_b1),
    .in_cin(in_cin1), .in_sub(in_sub1),
    .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1), .add_res(add_res1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_sum(out_sum1),
    .out_cout(out_cout1), .out_ovf(out_ovf1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model on w-bit operands: modular sum, unsigned carry/no-borrow,
  // overflow from exact signed arithmetic falling outside the w-bit range.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input logic sub, input int w);
    exp_t r;
    logic [63:0]        mask;
    logic [64:0]        wide;
    logic signed [65:0] sa, sb, res, lim;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    if (sub) begin
      r.sum  = (a - b) & mask;
      r.cout = (a >= b);
    end else begin
      wide   = {1'b0, a} + {1'b0, b} + {64'd0, cin};
      r.sum  = wide[63:0] & mask;
      r.cout = wide[w];
    end
    sa  = a[w-1] ? {2'b11, a | ~mask} : {2'b00, a};
    sb  = b[w-1] ? {2'b11, b | ~mask} : {2'b00, b};
    res = sub ? (sa - sb) : (sa + sb + {65'd0, cin});
    lim = 66'sd1 <<< (w - 1);
    r.ovf = (res >= lim) || (res < -lim);
    return r;
  endfunction

  // One WORDS=4 operation: accept, check first-cycle carry, wait for result,
  // optionally stall the consumer for 'hold' cycles, then drain and compare.
  task automatic run4(input logic [63:0] a, input logic [63:0] b,
                      input logic cin, input logic sub, input int hold);
    int   acc;
    int   n;
    exp_t e;
    @(negedge clk);
    n = 0;
    while (!in_ready4 && n < 20) begin @(negedge clk); n++; end
    check("w4_ready_timeout", 64'(in_ready4), 64'd1);
    in_valid4 = 1'b1; in_a4 = a; in_b4 = b; in_cin4 = cin; in_sub4 = sub;
    q4.push_back(model(a, b, cin, sub, 64));
    @(negedge clk);
    in_valid4 = 1'b0;
    acc = cyc;
    check("w4_first_cin", 64'(add_cin4), sub ? 64'd1 : 64'(cin));
    check("w4_first_add_a", 64'(add_a4), {48'd0, a[15:0]});
    n = 0;
    while (!out_valid4 && n < 40) begin @(negedge clk); n++; end
    check("w4_valid_timeout", 64'(out_valid4), 64'd1);
    check("w4_latency", 64'(cyc - acc), 64'd4);
    e = q4.pop_front();
    for (int i = 0; i < hold; i++) begin
      // Junk request while the result is pending must not be taken.
      in_valid4 = 1'b1; in_a4 = 64'hDEAD_BEEF_0000_1111; in_b4 = 64'h2222;
      check("w4_hold_valid", 64'(out_valid4), 64'd1);
      check("w4_hold_ready", 64'(in_ready4), 64'd0);
      check("w4_hold_sum", out_sum4, e.sum);
      check("w4_hold_flags", {62'd0, out_cout4, out_ovf4}, {62'd0, e.cout, e.ovf});
      @(negedge clk);
    end
    in_valid4 = 1'b0;
    check("w4_sum", out_sum4, e.sum);
    check("w4_cout", 64'(out_cout4), 64'(e.cout));
    check("w4_ovf", 64'(out_ovf4), 64'(e.ovf));
    out_ready4 = 1'b1;
    @(negedge clk);
    out_ready4 = 1'b0;
    check("w4_drain_valid", 64'(out_valid4), 64'd0);
    check("w4_drain_ready", 64'(in_ready4), 64'd1);
    check("w4_sum_held", out_sum4, e.sum);
  endtask

  initial begin
    int   n;
    int   acc;
    logic seen;
    exp_t e;
    logic [15:0] a1 [2] = '{16'h8000, 16'h0001};
    logic [15:0] b1 [2] = '{16'h8000, 16'h0002};
    logic        s1 [2] = '{1'b0, 1'b1};

    repeat (2) @(negedge clk);
    // Reset state
    check("rst_ready", 64'(in_ready4), 64'd1);
    check("rst_valid", 64'(out_valid4), 64'd0);
    check("rst_outs", {out_sum4[61:0], out_cout4, out_ovf4}, 64'd0);
    check("rst_slice", {47'd0, add_a4, add_cin4}, 64'd0);
    rst = 1'b0;

    run4(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0);
    run4(64'd5, 64'd7, 1'b0, 1'b1, 0);
    run4(64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 3);
    run4(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 0);
    for (int k = 0; k < 3; k++)
      run4({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom), k);

    // Reset pulsed mid-RUN at chunk index 2
    @(negedge clk);
    in_valid4 = 1'b1; in_a4 = 64'h1234_5678_9ABC_DEF0; in_b4 = 64'h1111; in_cin4 = 1'b0; in_sub4 = 1'b0;
    @(negedge clk);
    in_valid4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_run_idx2", 64'(add_a4), 64'h5678);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 64'(in_ready4), 64'd1);
    check("mid_rst_valid", 64'(out_valid4), 64'd0);
    check("mid_rst_outs", {out_sum4[61:0], out_cout4, out_ovf4}, 64'd0);
    check("mid_rst_slice", {31'd0, add_a4, add_b4, add_cin4}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid4) seen = 1'b1;
    end
    check("abandoned_no_result", 64'(seen), 64'd0);
    run4(64'h1_0000, 64'hFFFF, 1'b0, 1'b0, 0);

    // WORDS=1 instance
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n = 0;
      while (!in_ready1 && n < 20) begin @(negedge clk); n++; end
      check("w1_ready_timeout", 64'(in_ready1), 64'd1);
      in_valid1 = 1'b1; in_a1 = a1[k]; in_b1 = b1[k]; in_cin1 = 1'b0; in_sub1 = s1[k];
      q1.push_back(model({48'd0, a1[k]}, {48'd0, b1[k]}, 1'b0, s1[k], 16));
      @(negedge clk);
      in_valid1 = 1'b0;
      acc = cyc;
      check("w1_run_cin", 64'(add_cin1), 64'(s1[k]));
      n = 0;
      while (!out_valid1 && n < 20) begin @(negedge clk); n++; end
      check("w1_valid_timeout", 64'(out_valid1), 64'd1);
      check("w1_latency", 64'(cyc - acc), 64'd1);
      e = q1.pop_front();
      check("w1_sum", 64'(out_sum1), e.sum);
      check("w1_cout", 64'(out_cout1), 64'(e.cout));
      check("w1_ovf", 64'(out_ovf1), 64'(e.ovf));
      out_ready1 = 1'b1;
      @(negedge clk);
      out_ready1 = 1'b0;
      check("w1_drain_valid", 64'(out_valid1), 64'd0);
    end

    check("q4_empty", 64'(q4.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
